sorted_vec_serializer: RTL and testbench

Consumer for the bubble sorter's parallel result: accepts one sorted vector of DATA_N elements per valid/ready handshake and replays it as a serial element stream, one element per output handshake, with first/last framing. It holds a two-deep vector buffer (active + pending) so the sorter can deliver back-to-back vectors without gaps. An optional mode suppresses duplicate values within a vector.

---
 rtl/sorted_vec_serializer.sv | 111 +++++++++++
 tb/tb_sorted_vec_serializer.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sorted_vec_serializer.sv
// sorted_vec_serializer: accepts a sorted vector per handshake and replays it
// as a serial element stream with first/last framing. Two-deep vector buffer
// (active + pending) lets the upstream sorter deliver vectors back to back.
// With DEDUP=1, repeated values inside a vector are skipped.
module sorted_vec_serializer #(
    parameter int DATA_N = 4,
    parameter int DATA_W = 4,
    parameter bit DEDUP  = 1'b0,
    parameter int IDX_W  = $clog2(DATA_N)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           vec_valid,
    output logic                           vec_ready,
    input  logic [DATA_N-1:0][DATA_W-1:0]  vec_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_W-1:0]              out_data,
    output logic [IDX_W-1:0]               out_idx,
    output logic                           out_first,
    output logic                           out_last
);

    typedef logic [DATA_N-1:0][DATA_W-1:0] vec_t;

    // Buffer state
    logic             act_vld;
    logic             pend_vld;
    vec_t             act_vec;
    vec_t             pend_vec;
    logic [IDX_W-1:0] idx;

    // Per-cycle decode
    logic skip;
    logic is_last;
    logic vec_acc;
    logic out_hs;
    logic last_hs;
    logic load_act_new;
    logic load_act_pend;
    logic load_pend;

    // Slot classification: whether the current slot is skipped and whether it ends the vector
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        skip    = 1'b0;
        is_last = (idx == IDX_W'(DATA_N - 1));
        if (DEDUP) begin
            skip    = (idx != '0) && (act_vec[idx] == act_vec[idx - IDX_W'(1)]);
            is_last = (act_vec[idx] == act_vec[DATA_N-1]);
        end
    end

    // Handshakes and buffer routing
    assign vec_ready     = !pend_vld;
    assign vec_acc       = vec_valid && vec_ready;
    assign out_hs        = out_valid && out_ready;
    assign last_hs       = out_hs && out_last;
    // A new vector goes straight to active when active is idle, or when
    // active finishes this very cycle and nothing is waiting in pending.
    assign load_act_new  = vec_acc && (!act_vld || (last_hs && !pend_vld));
    assign load_act_pend = last_hs && pend_vld;
    assign load_pend     = vec_acc && act_vld && !last_hs;

    // Output stream; everything is forced to zero while active is empty
    assign out_valid = act_vld && !skip;
    assign out_data  = act_vld ? act_vec[idx] : '0;
    assign out_idx   = idx;
    assign out_first = act_vld && (idx == '0);
    assign out_last  = out_valid && is_last;

    // Control state: valid flags and element counter
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (!rst_n) begin
            act_vld  <= 1'b0;
            pend_vld <= 1'b0;
            idx      <= '0;
        end else begin
            if (load_act_new || load_act_pend) begin
                act_vld <= 1'b1;
                idx     <= '0;
            end else if (last_hs) begin
                act_vld <= 1'b0;
                idx     <= '0;
            end else if (out_hs || (act_vld && skip)) begin
                idx <= idx + IDX_W'(1);
            end

            if (load_act_pend) begin
                pend_vld <= 1'b0;
            end else if (load_pend) begin
                pend_vld <= 1'b1;
            end
        end
    end

    // Vector storage, qualified by act_vld/pend_vld
    always_ff @(posedge clk) begin
        // NOTE: vector storage has no reset; its contents are never observed while the matching valid flag is low.
        if (load_act_pend) begin
            act_vec <= pend_vec;
        end else if (load_act_new) begin
            act_vec <= vec_data;
        end
        if (load_pend) begin
            pend_vec <= vec_data;
        end
    end

endmodule

// File: tb/tb_sorted_vec_serializer.sv
// Testbench for sorted_vec_serializer: directed scenarios on a DEDUP=0 and a
// DEDUP=1 instance, then randomized traffic against a queue-based model.
module tb_sorted_vec_serializer;

    localparam int N  = 4;
    localparam int W  = 4;
    localparam int IW = 2;
    localparam int RING = 16;

    typedef logic [N-1:0][W-1:0] vec_t;
    typedef struct {
        logic [W-1:0]  data;
        logic [IW-1:0] idx;
        logic          first;
        logic          last;
    } elem_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          vec_valid [2];
    vec_t          vec_data  [2];
    logic          vec_ready [2];
    logic          out_valid [2];
    logic          out_ready [2];
    logic [W-1:0]  out_data  [2];
    logic [IW-1:0] out_idx   [2];
    logic          out_first [2];
    logic          out_last  [2];

    int n_cmp = 0;
    int n_err = 0;

    sorted_vec_serializer #(.DATA_N(N), .DATA_W(W), .DEDUP(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .vec_valid(vec_valid[0]), .vec_ready(vec_ready[0]), .vec_data(vec_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_idx(out_idx[0]), .out_first(out_first[0]), .out_last(out_last[0])
    );

    sorted_vec_serializer #(.DATA_N(N), .DATA_W(W), .DEDUP(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .vec_valid(vec_valid[1]), .vec_ready(vec_ready[1]), .vec_data(vec_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_idx(out_idx[1]), .out_first(out_first[1]), .out_last(out_last[1])
    );

    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled and inputs driven at the falling edge
    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mkvec(int a0, int a1, int a2, int a3);
        vec_t v;
        v[0] = W'(a0);
        v[1] = W'(a1);
        v[2] = W'(a2);
        v[3] = W'(a3);
        return v;
    endfunction

    // {vec_ready, out_valid, out_first, out_last, out_idx, out_data}
    function automatic logic [9:0] mk(bit rdy, bit v, bit f, bit l, int i, int data);
        return {rdy, v, f, l, IW'(i), W'(data)};
    endfunction

    function automatic logic [9:0] obs(int d);
        return {vec_ready[d], out_valid[d], out_first[d], out_last[d], out_idx[d], out_data[d]};
    endfunction

    task automatic idle_inputs();
        for (int d = 0; d < 2; d++) begin
            vec_valid[d] = 1'b0;
            vec_data[d]  = '0;
            out_ready[d] = 1'b1;
        end
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [9:0] got;
        @(negedge clk);
        apply_reset();
        for (int d = 0; d < 2; d++) begin
            got = obs(d);
            n_cmp++;
            if (got !== mk(1, 0, 0, 0, 0, 0)) begin
                n_err++;
                $display("FAIL reset dut%0d: got %h want %h", d, got, mk(1, 0, 0, 0, 0, 0));
            end
        end
        // Offers made while reset is held must be ignored
        rst_n = 1'b0;
        vec_valid[0] = 1'b1;
        vec_data[0]  = mkvec(9, 7, 3, 1);
        cycle();
        cycle();
        vec_valid[0] = 1'b0;
        rst_n = 1'b1;
        got = obs(0);
        n_cmp++;
        if (got !== mk(1, 0, 0, 0, 0, 0)) begin
            n_err++;
            $display("FAIL reset_ignore: got %h want %h", got, mk(1, 0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_basic();
        logic [9:0] want [6];
        logic [9:0] got;
        want = '{mk(1,1,1,0,0,9), mk(1,1,0,0,1,7), mk(1,1,0,0,2,3), mk(1,1,0,1,3,1),
                 mk(1,0,0,0,0,0), mk(1,0,0,0,0,0)};
        apply_reset();
        vec_valid[0] = 1'b1;
        vec_data[0]  = mkvec(9, 7, 3, 1);
        cycle();
        for (int j = 0; j < 6; j++) begin
            got = obs(0);
            if (!want[j][8]) got = got & 10'h300;
            n_cmp++;
            if (got !== want[j]) begin
                n_err++;
                $display("FAIL basic[%0d]: got %h want %h", j, got, want[j]);
            end
            if (j == 0) vec_valid[0] = 1'b0;
            cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic [9:0] want [13];
        logic [9:0] got;
        want = '{mk(1,1,1,0,0,9), mk(0,1,0,0,1,7), mk(0,1,0,0,2,3), mk(0,1,0,1,3,1),
                 mk(1,1,1,0,0,8), mk(0,1,0,0,1,6), mk(0,1,0,0,2,4), mk(0,1,0,1,3,2),
                 mk(1,1,1,0,0,6), mk(1,1,0,0,1,5), mk(1,1,0,0,2,5), mk(1,1,0,1,3,0),
                 mk(1,0,0,0,0,0)};
        apply_reset();
        vec_valid[0] = 1'b1;
        vec_data[0]  = mkvec(9, 7, 3, 1);
        cycle();
        for (int j = 0; j < 13; j++) begin
            got = obs(0);
            if (!want[j][8]) got = got & 10'h300;
            n_cmp++;
            if (got !== want[j]) begin
                n_err++;
                $display("FAIL back_to_back[%0d]: got %h want %h", j, got, want[j]);
            end
            case (j)
                0: vec_data[0] = mkvec(8, 6, 4, 2);
                1: vec_data[0] = mkvec(6, 5, 5, 0);
                5: vec_valid[0] = 1'b0;
                default: ;
            endcase
            cycle();
        end
    endtask

    task automatic test_backpressure();
        logic [9:0] want [8];
        logic [9:0] got;
        want = '{mk(1,1,1,0,0,9), mk(1,1,0,0,1,7), mk(1,1,0,0,1,7), mk(1,1,0,0,1,7),
                 mk(1,1,0,0,1,7), mk(1,1,0,0,2,3), mk(1,1,0,1,3,1), mk(1,0,0,0,0,0)};
        apply_reset();
        vec_valid[0] = 1'b1;
        vec_data[0]  = mkvec(9, 7, 3, 1);
        cycle();
        for (int j = 0; j < 8; j++) begin
            got = obs(0);
            if (!want[j][8]) got = got & 10'h300;
            n_cmp++;
            if (got !== want[j]) begin
                n_err++;
                $display("FAIL backpressure[%0d]: got %h want %h", j, got, want[j]);
            end
            case (j)
                0: vec_valid[0] = 1'b0;
                1: out_ready[0] = 1'b0;
                4: out_ready[0] = 1'b1;
                default: ;
            endcase
            cycle();
        end
    endtask

    task automatic test_dedup();
        logic [9:0] want [6];
        logic [9:0] got;
        want = '{mk(1,1,1,0,0,5), mk(1,0,0,0,0,0), mk(1,1,0,1,2,2), mk(1,0,0,0,0,0),
                 mk(1,1,1,1,0,4), mk(1,0,0,0,0,0)};
        apply_reset();
        vec_valid[1] = 1'b1;
        vec_data[1]  = mkvec(5, 5, 2, 2);
        cycle();
        for (int j = 0; j < 6; j++) begin
            got = obs(1);
            if (!want[j][8]) got = got & 10'h300;
            n_cmp++;
            if (got !== want[j]) begin
                n_err++;
                $display("FAIL dedup[%0d]: got %h want %h", j, got, want[j]);
            end
            case (j)
                0: vec_valid[1] = 1'b0;
                3: begin
                    vec_valid[1] = 1'b1;
                    vec_data[1]  = mkvec(4, 4, 4, 4);
                end
                4: vec_valid[1] = 1'b0;
                default: ;
            endcase
            cycle();
        end
    endtask

    task automatic test_accept_on_last();
        logic [9:0] want [9];
        logic [9:0] got;
        want = '{mk(1,1,1,0,0,9), mk(1,1,0,0,1,7), mk(1,1,0,0,2,3), mk(1,1,0,1,3,1),
                 mk(1,1,1,0,0,8), mk(1,1,0,0,1,6), mk(1,1,0,0,2,4), mk(1,1,0,1,3,2),
                 mk(1,0,0,0,0,0)};
        apply_reset();
        vec_valid[0] = 1'b1;
        vec_data[0]  = mkvec(9, 7, 3, 1);
        cycle();
        for (int j = 0; j < 9; j++) begin
            got = obs(0);
            if (!want[j][8]) got = got & 10'h300;
            n_cmp++;
            if (got !== want[j]) begin
                n_err++;
                $display("FAIL accept_on_last[%0d]: got %h want %h", j, got, want[j]);
            end
            case (j)
                0: vec_valid[0] = 1'b0;
                3: begin
                    vec_valid[0] = 1'b1;
                    vec_data[0]  = mkvec(8, 6, 4, 2);
                end
                4: vec_valid[0] = 1'b0;
                default: ;
            endcase
            cycle();
        end
    endtask

    task automatic test_reset_midstream();
        logic [9:0] want [9];
        logic [9:0] got;
        want = '{mk(1,1,1,0,0,9), mk(0,1,0,0,1,7), mk(0,1,0,0,2,3), mk(1,0,0,0,0,0),
                 mk(1,1,1,0,0,3), mk(1,1,0,0,1,2), mk(1,1,0,0,2,1), mk(1,1,0,1,3,0),
                 mk(1,0,0,0,0,0)};
        apply_reset();
        vec_valid[0] = 1'b1;
        vec_data[0]  = mkvec(9, 7, 3, 1);
        cycle();
        for (int j = 0; j < 9; j++) begin
            got = obs(0);
            if (!want[j][8]) got = got & 10'h300;
            n_cmp++;
            if (got !== want[j]) begin
                n_err++;
                $display("FAIL reset_midstream[%0d]: got %h want %h", j, got, want[j]);
            end
            case (j)
                0: vec_data[0] = mkvec(8, 6, 4, 2);
                1: vec_valid[0] = 1'b0;
                2: rst_n = 1'b0;
                3: begin
                    rst_n        = 1'b1;
                    vec_valid[0] = 1'b1;
                    vec_data[0]  = mkvec(3, 2, 1, 0);
                end
                4: vec_valid[0] = 1'b0;
                default: ;
            endcase
            cycle();
        end
    endtask

    // Random descending vector; a narrow value range makes duplicates common
    function automatic vec_t rand_sorted_vec();
        int a [N];
        int t;
        int hi;
        vec_t v;
        hi = ($urandom_range(0, 1) == 0) ? 3 : 15;
        for (int i = 0; i < N; i++) a[i] = int'($urandom_range(0, hi));
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < N - 1 - i; k++) begin
                if (a[k] < a[k+1]) begin
                    t = a[k]; a[k] = a[k+1]; a[k+1] = t;
                end
            end
        end
        for (int i = 0; i < N; i++) v[i] = W'(a[i]);
        return v;
    endfunction

    task automatic test_random();
        elem_t ring [2][RING];
        int    head [2];
        int    cnt  [2];
        int    occ  [2];
        bit    acc_prev [2];
        elem_t e;
        bit    acc;
        bit    hs;
        bit    drain;
        int    tail;
        logic [7:0] got8;
        logic [7:0] want8;
        apply_reset();
        for (int d = 0; d < 2; d++) begin
            head[d] = 0; cnt[d] = 0; occ[d] = 0; acc_prev[d] = 1'b0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            drain = (cyc >= 2940);
            for (int d = 0; d < 2; d++) begin
                // Capacity: two vectors in flight means pending is full
                n_cmp++;
                if (vec_ready[d] !== (occ[d] < 2)) begin
                    n_err++;
                    $display("FAIL rnd_ready dut%0d cyc %0d: got %b want %b", d, cyc, vec_ready[d], occ[d] < 2);
                end
                if (out_valid[d] === 1'b1) begin
                    n_cmp++;
                    if (cnt[d] == 0) begin
                        n_err++;
                        $display("FAIL rnd_extra dut%0d cyc %0d: got element %h, want none", d, cyc, out_data[d]);
                    end else begin
                        e = ring[d][head[d]];
                        got8  = {out_data[d], out_idx[d], out_first[d], out_last[d]};
                        want8 = {e.data, e.idx, e.first, e.last};
                        if (got8 !== want8) begin
                            n_err++;
                            $display("FAIL rnd_elem dut%0d cyc %0d: got %h want %h", d, cyc, got8, want8);
                        end
                    end
                end else begin
                    // Without dedup a held vector is always presenting an element
                    n_cmp++;
                    if (out_valid[d] !== 1'b0 || (d == 0 && occ[d] > 0)) begin
                        n_err++;
                        $display("FAIL rnd_valid dut%0d cyc %0d: got %b with %0d vectors held", d, cyc, out_valid[d], occ[d]);
                    end
                end

                // Source: hold an offer until taken, then maybe offer another
                if (!vec_valid[d] || acc_prev[d]) begin
                    if (!drain && $urandom_range(0, 2) != 0) begin
                        vec_valid[d] = 1'b1;
                        vec_data[d]  = rand_sorted_vec();
                    end else begin
                        vec_valid[d] = 1'b0;
                    end
                end
                out_ready[d] = drain ? 1'b1 : ($urandom_range(0, 3) != 0);

                // Model update for the coming edge
                acc = vec_valid[d] && (occ[d] < 2);
                hs  = (out_valid[d] === 1'b1) && out_ready[d] && (cnt[d] > 0);
                if (hs) begin
                    e = ring[d][head[d]];
                    head[d] = (head[d] + 1) % RING;
                    cnt[d]--;
                    if (e.last) occ[d]--;
                end
                if (acc) begin
                    for (int i = 0; i < N; i++) begin
                        if (d == 0 || i == 0 || vec_data[d][i] != vec_data[d][i-1]) begin
                            tail = (head[d] + cnt[d]) % RING;
                            ring[d][tail].data  = vec_data[d][i];
                            ring[d][tail].idx   = IW'(i);
                            ring[d][tail].first = (i == 0);
                            ring[d][tail].last  = 1'b0;
                            cnt[d]++;
                        end
                    end
                    ring[d][(head[d] + cnt[d] - 1) % RING].last = 1'b1;
                    occ[d]++;
                end
                acc_prev[d] = acc;
            end
            cycle();
        end
        for (int d = 0; d < 2; d++) begin
            n_cmp++;
            if (cnt[d] != 0 || out_valid[d] !== 1'b0) begin
                n_err++;
                $display("FAIL rnd_drain dut%0d: got %0d elements left, out_valid %b; want 0, 0", d, cnt[d], out_valid[d]);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        test_reset();
        test_basic();
        test_back_to_back();
        test_backpressure();
        test_dedup();
        test_accept_on_last();
        test_reset_midstream();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
